// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One op per WIDTH+1 cycles: WIDTH shift-add/restoring steps, then a sign-fix/write cycle.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] acc_hi, acc_hi_d;
    logic [WIDTH-1:0] acc_lo, acc_lo_d;
    logic [WIDTH-1:0] mag_a, mag_a_d;
    logic [WIDTH-1:0] mag_b, mag_b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             is_div, is_div_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             b_zero, b_zero_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d, dbz_d;

    logic             sa_c, sb_c;
    logic [WIDTH-1:0] in_mag_a_c, in_mag_b_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   shifted_c;
    logic             ge_c;
    logic [WIDTH-1:0] diff_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c, rem_c;

    // Operand magnitudes at issue; unsigned ops never take the negate path.
    always_comb begin
        sa_c       = ~op[0] & a[WIDTH-1];
        sb_c       = ~op[0] & b[WIDTH-1];
        in_mag_a_c = sa_c ? -a : a;
        in_mag_b_c = sb_c ? -b : b;
    end

    // One iteration step for each engine plus the final sign correction.
    always_comb begin
        sum_c     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        shifted_c = {acc_hi, acc_lo[WIDTH-1]};
        ge_c      = shifted_c >= {1'b0, mag_b};
        // Only used when ge_c holds, so the true difference fits in WIDTH bits.
        diff_c    = shifted_c[WIDTH-1:0] - mag_b;
        prod_c    = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_c     = neg_q ? -acc_lo : acc_lo;
        rem_c     = neg_r ? -acc_hi : acc_hi;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        acc_hi_d = acc_hi;
        acc_lo_d = acc_lo;
        mag_a_d  = mag_a;
        mag_b_d  = mag_b;
        a_d      = a_q;
        is_div_d = is_div;
        neg_q_d  = neg_q;
        neg_r_d  = neg_r;
        b_zero_d = b_zero;
        hi_d     = hi;
        lo_d     = lo;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        state_d  = CALC;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        mag_a_d  = in_mag_a_c;
                        mag_b_d  = in_mag_b_c;
                        a_d      = a;
                        neg_q_d  = sa_c ^ sb_c;
                        neg_r_d  = sa_c;
                        b_zero_d = (b == '0);
                        acc_hi_d = '0;
                        acc_lo_d = op[1] ? in_mag_a_c : in_mag_b_c;
                    end else if (!op[1]) begin
                        if (op[0]) lo_d = a;
                        else       hi_d = a;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_div) begin
                        acc_hi_d = ge_c ? diff_c : shifted_c[WIDTH-1:0];
                        acc_lo_d = {acc_lo[WIDTH-2:0], ge_c};
                    end else begin
                        acc_hi_d = sum_c[WIDTH:1];
                        acc_lo_d = {sum_c[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div && b_zero) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else if (is_div) begin
                        hi_d = rem_c;
                        lo_d = quo_c;
                    end else begin
                        hi_d = prod_c[PW-1:WIDTH];
                        lo_d = prod_c[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            a_q         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            acc_hi      <= acc_hi_d;
            acc_lo      <= acc_lo_d;
            mag_a       <= mag_a_d;
            mag_b       <= mag_b_d;
            a_q         <= a_d;
            is_div      <= is_div_d;
            neg_q       <= neg_q_d;
            neg_r       <= neg_r_d;
            b_zero      <= b_zero_d;
            hi          <= hi_d;
            lo          <= lo_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule
